mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 20 ++
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_pkg.sv
// Shared types for the multiply/divide unit.
//   opT    : operation encoding presented on the op input
//   stateT : sequencing states of the iterative datapath
package mult_div_pkg;

   typedef enum logic [1:0] {
      OpMult  = 2'b00,
      OpMultu = 2'b01,
      OpDiv   = 2'b10,
      OpDivu  = 2'b11
   } opT;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StFix  = 2'b10,
      StDone = 2'b11
   } stateT;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MIPS style).
// Signed operations work on operand magnitudes and fix the sign afterwards.
// One shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle.
// Ports:
//   clock, res          : clock, asynchronous active-low reset
//   start, op, a, b     : operation request, accepted only while idle
//   write_hi, write_lo  : direct HI/LO load from wdata, honoured only while idle
//   busy, done          : not idle / one-cycle completion pulse
//   div_zero            : divide by zero on the last operation, cleared on next accept
//   hi, lo              : result registers
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             res,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             write_hi,
   input  logic             write_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   stateT              stateQ, stateD;
   opT                 opQ, opD;
   logic [CntW-1:0]    cntQ, cntD;
   // Multiply: {partial product, multiplier}; divide: low half is dividend/quotient.
   logic [2*WIDTH-1:0] accQ, accD;
   logic [WIDTH:0]     remQ, remD;
   logic [WIDTH-1:0]   magAQ, magAD, magBQ, magBD;
   logic               signAQ, signAD, signBQ, signBD;
   logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
   logic               divZeroQ, divZeroD;

   logic               signedIn, signedQ, isDivQ;
   logic [WIDTH-1:0]   magA, magB, addend, quo, rmd;
   logic [WIDTH:0]     sum;
   logic [WIDTH+1:0]   shifted;
   logic               qBit;
   logic [2*WIDTH-1:0] prod;

   assign signedIn = (op == OpMult) || (op == OpDiv);
   assign signedQ  = (opQ == OpMult) || (opQ == OpDiv);
   assign isDivQ   = (opQ == OpDiv) || (opQ == OpDivu);

   always_comb begin
      stateD   = stateQ;
      opD      = opQ;
      cntD     = cntQ;
      accD     = accQ;
      remD     = remQ;
      magAD    = magAQ;
      magBD    = magBQ;
      signAD   = signAQ;
      signBD   = signBQ;
      hiD      = hiQ;
      loD      = loQ;
      divZeroD = divZeroQ;
      magA     = (signedIn && a[WIDTH-1]) ? -a : a;
      magB     = (signedIn && b[WIDTH-1]) ? -b : b;
      addend   = '0;
      sum      = '0;
      shifted  = '0;
      qBit     = 1'b0;
      prod     = '0;
      quo      = '0;
      rmd      = '0;

      unique case (stateQ)
         StIdle: begin
            if (write_hi) hiD = wdata;
            if (write_lo) loD = wdata;
            if (start) begin
               opD      = opT'(op);
               divZeroD = 1'b0;
               if (op[1] && (b == '0)) begin
                  // Divide by zero bypasses the datapath; overrides a same-cycle write.
                  stateD   = StDone;
                  divZeroD = 1'b1;
                  hiD      = a;
                  loD      = '1;
               end else begin
                  stateD = StRun;
                  cntD   = CntW'(WIDTH);
                  magAD  = magA;
                  magBD  = magB;
                  signAD = a[WIDTH-1];
                  signBD = b[WIDTH-1];
                  remD   = '0;
                  accD   = op[1] ? {{WIDTH{1'b0}}, magA} : {{WIDTH{1'b0}}, magB};
               end
            end
         end

         StRun: begin
            cntD = cntQ - CntW'(1);
            if (isDivQ) begin
               shifted = {remQ, accQ[WIDTH-1]};
               if (shifted >= {2'b00, magBQ}) begin
                  remD = (WIDTH + 1)'(shifted - {2'b00, magBQ});
                  qBit = 1'b1;
               end else begin
                  remD = shifted[WIDTH:0];
               end
               accD = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-2:0], qBit};
            end else begin
               addend = accQ[0] ? magAQ : '0;
               sum    = {1'b0, accQ[2*WIDTH-1:WIDTH]} + {1'b0, addend};
               accD   = {sum, accQ[WIDTH-1:1]};
            end
            if (cntQ == CntW'(1)) stateD = StFix;
         end

         StFix: begin
            if (isDivQ) begin
               quo = accQ[WIDTH-1:0];
               rmd = remQ[WIDTH-1:0];
               if (signedQ && (signAQ ^ signBQ)) quo = -quo;
               if (signedQ && signAQ) rmd = -rmd;
               hiD = rmd;
               loD = quo;
            end else begin
               prod = accQ;
               if (signedQ && (signAQ ^ signBQ)) prod = -accQ;
               hiD = prod[2*WIDTH-1:WIDTH];
               loD = prod[WIDTH-1:0];
            end
            stateD = StDone;
         end

         StDone: begin
            stateD = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge res) begin
      if (!res) begin
         stateQ   <= StIdle;
         opQ      <= OpMult;
         cntQ     <= '0;
         accQ     <= '0;
         remQ     <= '0;
         magAQ    <= '0;
         magBQ    <= '0;
         signAQ   <= 1'b0;
         signBQ   <= 1'b0;
         hiQ      <= '0;
         loQ      <= '0;
         divZeroQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         opQ      <= opD;
         cntQ     <= cntD;
         accQ     <= accD;
         remQ     <= remD;
         magAQ    <= magAD;
         magBQ    <= magBD;
         signAQ   <= signAD;
         signBQ   <= signBD;
         hiQ      <= hiD;
         loQ      <= loD;
         divZeroQ <= divZeroD;
      end
   end

   assign busy     = (stateQ != StIdle);
   assign done     = (stateQ == StDone);
   assign div_zero = divZeroQ;
   assign hi       = hiQ;
   assign lo       = loQ;

endmodule
